moore_3_steer: RTL

Initiator-side controller for the team's 3-state Moore machine (states W=00, X=01, Y=10; input x, output y, y=1 only in X). It accepts a requested target state over a valid/ready handshake and drives x plus a step enable so that the controlled FSM advances along the shortest legal path to that state. It tracks the controlled FSM in a shadow state register. It also checks the controlled FSM's observed y against the expected Moore output and flags any divergence.

---
 rtl/moore_3_steer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/moore_3_steer.sv
// moore_3_steer: initiator-side controller for the 3-state Moore machine
// (W=00, X=01, Y=10; output y=1 only in X). It accepts a target state over a
// valid/ready handshake and steps the controlled FSM along the shortest legal
// path to it. It keeps a shadow copy of the controlled FSM state and checks
// the controlled FSM's registered y against the Moore output it should show.
module moore_3_steer #(
    parameter int unsigned STEP_GAP = 0,    // idle cycles between path steps (0..15)
    parameter bit          CHECK_EN = 1'b1  // 0 keeps err_mismatch at 0
) (
    input  logic       clk,
    input  logic       rst,          // synchronous, active-low
    input  logic       req_valid,
    input  logic [1:0] req_state,
    output logic       req_ready,
    output logic       x,
    output logic       step,
    input  logic       y_obs,
    output logic       done,
    output logic       err_invalid,
    output logic       err_mismatch,
    output logic [1:0] cur_state
);

    // Encodings of the controlled machine's states.
    localparam logic [1:0] ST_W   = 2'b00;
    localparam logic [1:0] ST_X   = 2'b01;
    localparam logic [1:0] ST_Y   = 2'b10;
    localparam logic [1:0] ST_BAD = 2'b11;

    // The GAP state is unreachable when no gap is configured.
    localparam bit         HAS_GAP  = (STEP_GAP != 0);
    localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(STEP_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        C_IDLE = 2'b00,
        C_STEP = 2'b01,
        C_GAP  = 2'b10,
        C_DONE = 2'b11
    } ctrl_t;

    ctrl_t      ctrl_q,  ctrl_d;
    logic [1:0] target_q, target_d;
    logic [3:0] gap_q,    gap_d;
    logic       chk_pending_q, chk_pending_d;  // previous cycle was a step
    logic       chk_exp_q,     chk_exp_d;      // y expected in the cycle after that step

    logic [1:0] shadow_d;
    logic       req_ready_d;
    logic       x_d;
    logic       step_d;
    logic       done_d;
    logic       err_invalid_d;
    logic       err_mismatch_d;

    // Transition table of the controlled machine.
    function automatic logic [1:0] advance(input logic [1:0] s, input logic xb);
        case (s)
            ST_W:    return xb ? ST_X : ST_Y;
            ST_X:    return xb ? ST_Y : ST_X;
            ST_Y:    return xb ? ST_W : ST_Y;
            default: return ST_W;
        endcase
    endfunction

    // Steering bit toward target t: only W has a choice; X and Y always
    // move forward around the ring (X->Y->W).
    function automatic logic steer(input logic [1:0] s, input logic [1:0] t);
        return (s == ST_W) ? (t == ST_X) : 1'b1;
    endfunction

    // Next-state and next-output decode for the control FSM and shadow.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case leaves one unassigned, which would infer a latch.
        ctrl_d         = ctrl_q;
        target_d       = target_q;
        gap_d          = gap_q;
        shadow_d       = cur_state;
        req_ready_d    = 1'b0;
        x_d            = 1'b0;
        step_d         = 1'b0;
        done_d         = 1'b0;
        err_invalid_d  = 1'b0;
        err_mismatch_d = err_mismatch;
        chk_pending_d  = step;
        chk_exp_d      = (cur_state == ST_X);

        // The controlled FSM registers y, so in the cycle after a step it
        // still shows the Moore output of the pre-step state.
        if (CHECK_EN && chk_pending_q && (y_obs != chk_exp_q)) begin
            err_mismatch_d = 1'b1;
        end

        // The shadow moves only on cycles in which step is driven.
        if (step) begin
            shadow_d = advance(cur_state, x);
        end

        case (ctrl_q)
            C_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    if (req_state == ST_BAD) begin
                        err_invalid_d = 1'b1;
                    end else if (req_state == cur_state) begin
                        ctrl_d      = C_DONE;
                        done_d      = 1'b1;
                        req_ready_d = 1'b0;
                    end else begin
                        ctrl_d      = C_STEP;
                        target_d    = req_state;
                        step_d      = 1'b1;
                        x_d         = steer(cur_state, req_state);
                        req_ready_d = 1'b0;
                    end
                end
            end

            C_STEP: begin
                if (shadow_d == target_q) begin
                    ctrl_d = C_DONE;
                    done_d = 1'b1;
                end else if (HAS_GAP) begin
                    ctrl_d = C_GAP;
                    gap_d  = GAP_LAST;
                end else begin
                    step_d = 1'b1;
                    x_d    = steer(shadow_d, target_q);
                end
            end

            C_GAP: begin
                if (gap_q == 4'd0) begin
                    ctrl_d = C_STEP;
                    step_d = 1'b1;
                    x_d    = steer(cur_state, target_q);
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            C_DONE: begin
                ctrl_d      = C_IDLE;
                req_ready_d = 1'b1;
            end

            default: begin
                ctrl_d      = C_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered-output flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge, independent of statement order.
        if (!rst) begin
            ctrl_q        <= C_IDLE;
            target_q      <= ST_W;
            gap_q         <= 4'd0;
            chk_pending_q <= 1'b0;
            chk_exp_q     <= 1'b0;
            cur_state     <= ST_W;
            req_ready     <= 1'b1;
            x             <= 1'b0;
            step          <= 1'b0;
            done          <= 1'b0;
            err_invalid   <= 1'b0;
            err_mismatch  <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            target_q      <= target_d;
            gap_q         <= gap_d;
            chk_pending_q <= chk_pending_d;
            chk_exp_q     <= chk_exp_d;
            cur_state     <= shadow_d;
            req_ready     <= req_ready_d;
            x             <= x_d;
            step          <= step_d;
            done          <= done_d;
            err_invalid   <= err_invalid_d;
            err_mismatch  <= err_mismatch_d;
        end
    end

endmodule
